header_rx_assembler: RTL and testbench

HEADER_RX_ASSEMBLER -- requirements
Module: header_rx_assembler

---
 rtl/header_rx_assembler_pkg.sv | 16 +
 rtl/header_rx_assembler_idle_timer.sv | 32 +++
 rtl/header_rx_assembler.sv | 117 +++++++++++
 tb/tb_header_rx_assembler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/header_rx_assembler_pkg.sv
// rtl/header_rx_assembler_pkg.sv - shared constants and state encoding for the header receiver
// Purpose: default frame/timeout sizes, header width and FSM state type.
// Ports: none (package).
package header_rx_assembler_pkg;

  localparam int HEADER_BYTES   = 80;
  localparam int TIMEOUT_CYCLES = 50_000_000;
  localparam int HEADER_W       = 8 * HEADER_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/header_rx_assembler_idle_timer.sv
// rtl/header_rx_assembler_idle_timer.sv - mid-frame idle cycle counter with terminal count
// Purpose: counts enabled cycles since the last clear; tc flags TIMEOUT_CYCLES-1.
// Ports: clock, reset (async, active-high), clear (sync zero), enable (count), tc (terminal count).
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Holds at terminal count so the counter can never wrap back past it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/header_rx_assembler.sv
// rtl/header_rx_assembler.sv - assembles fixed-length block headers from a UART byte stream
// Purpose: collects HEADER_BYTES bytes MSB-first into block_header, with idle timeout and abort.
// Ports: clock, reset (async, active-high); rx_data/rx_valid byte strobe; clear abort;
//        block_header, header_valid pulse, timeout_err pulse, busy, byte_count (accepted bytes).
module header_rx_assembler
  import header_rx_assembler_pkg::*;
#(
  parameter int HEADER_BYTES   = header_rx_assembler_pkg::HEADER_BYTES,
  parameter int TIMEOUT_CYCLES = header_rx_assembler_pkg::TIMEOUT_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      clear,
  output logic [8*HEADER_BYTES-1:0] block_header,
  output logic                      header_valid,
  output logic                      timeout_err,
  output logic                      busy,
  output logic [31:0]               byte_count
);

  localparam int HW = 8 * HEADER_BYTES;
  localparam int IW = $clog2(HEADER_BYTES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(HEADER_BYTES - 1);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [HW-1:0] shreg;
  logic [HW-1:0] shreg_next;
  logic [31:0]   byte_cnt;
  logic          accept;
  logic          last_byte;
  logic          tc;
  logic          timeout_hit;
  logic          timer_clear;
  logic          timer_enable;

  // clear suppresses the byte outright, so it is never counted or stored.
  assign accept      = rx_valid & ~clear;
  assign last_byte   = (state == RECV) & accept & (idx == LAST_IDX);
  // A byte arriving on the terminal cycle wins over the timeout.
  assign timeout_hit = (state == RECV) & ~clear & ~rx_valid & tc;
  // Shifting left leaves byte 0 in the top lane once all bytes are in.
  assign shreg_next  = {shreg[HW-9:0], rx_data};

  assign timer_clear  = accept | clear | (state != RECV);
  assign timer_enable = (state == RECV) & ~rx_valid;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tc     (tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = RECV;
      end
      RECV: begin
        if (clear || timeout_hit) begin
          state_next = IDLE;
        end else if (last_byte) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = accept ? RECV : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      shreg        <= '0;
      block_header <= '0;
      timeout_err  <= 1'b0;
      byte_cnt     <= '0;
    end else begin
      timeout_err <= timeout_hit;
      if (accept) begin
        byte_cnt <= byte_cnt + 32'd1;
        shreg    <= shreg_next;
      end
      if (last_byte) begin
        block_header <= shreg_next;
      end
      if (clear || timeout_hit || last_byte) begin
        idx <= '0;
      end else if (accept) begin
        idx <= (state == RECV) ? idx + 1'b1 : IW'(1);
      end
    end
  end

  assign header_valid = (state == DONE);
  assign busy         = (state == RECV);
  assign byte_count   = byte_cnt;

endmodule

// File: tb/tb_header_rx_assembler.sv
// tb/tb_header_rx_assembler.sv - self-checking bench for header_rx_assembler
module tb_header_rx_assembler;

  localparam int HB = 80;
  localparam int TO = 100;
  localparam int HW = 8 * HB;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clear;
  logic [HW-1:0] block_header;
  logic          header_valid;
  logic          timeout_err;
  logic          busy;
  logic [31:0]   byte_count;

  int n_cmp = 0;
  int n_bad = 0;
  int hv_seen;
  int to_seen;

  // Reference model: frame-in-progress as a byte queue.
  logic [7:0]    m_q[$];
  logic [HW-1:0] m_hdr;
  logic [31:0]   m_cnt;
  int            m_idle;
  bit            m_hv;
  bit            m_to;

  always #5 clock = ~clock;

  header_rx_assembler #(
    .HEADER_BYTES   (HB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .clear        (clear),
    .block_header (block_header),
    .header_valid (header_valid),
    .timeout_err  (timeout_err),
    .busy         (busy),
    .byte_count   (byte_count)
  );

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hdr  = '0;
    m_cnt  = '0;
    m_idle = 0;
    m_hv   = 1'b0;
    m_to   = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    m_hv = 1'b0;
    m_to = 1'b0;
    if (c) begin
      m_q.delete();
      m_idle = 0;
    end else if (v) begin
      m_q.push_back(d);
      m_cnt  = m_cnt + 32'd1;
      m_idle = 0;
      if (m_q.size() == HB) begin
        for (int i = 0; i < HB; i++) m_hdr[8*(HB-1-i) +: 8] = m_q[i];
        m_hv = 1'b1;
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_q.delete();
        m_idle = 0;
        m_to   = 1'b1;
      end
    end else begin
      m_idle = 0;
    end
  endtask

  // Called at a negedge: drive, clock, advance the model, compare at next negedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit c);
    rx_valid = v;
    rx_data  = d;
    clear    = c;
    @(posedge clock);
    model_step(v, d, c);
    @(negedge clock);
    check("header_valid", header_valid, m_hv);
    check("timeout_err", timeout_err, m_to);
    check("busy", busy, m_q.size() > 0);
    check("byte_count", byte_count, m_cnt);
    check("block_header", block_header, m_hdr);
    check("pulse_exclusive", header_valid & timeout_err, 0);
    hv_seen += int'(header_valid);
    to_seen += int'(timeout_err);
    rx_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 8'($urandom), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt_before;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    clear    = 1'b0;
    hv_seen  = 0;
    to_seen  = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_block_header", block_header, 0);
    check("rst_header_valid", header_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_byte_count", byte_count, 0);
    reset = 1'b0;

    // Ascending frame, back-to-back
    hv_seen = 0;
    for (int i = 0; i < HB; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("asc_hv_count", hv_seen, 1);
    check("asc_first_byte", block_header[HW-1 -: 8], 8'h00);
    check("asc_last_byte", block_header[7:0], 8'h4F);
    check("asc_byte_count", byte_count, 80);

    // Partial frame then timeout
    to_seen = 0;
    hv_seen = 0;
    send_random(40);
    repeat (TO) cycle(1'b0, 8'h00, 1'b0);
    check("to_pulse_count", to_seen, 1);
    check("to_busy", busy, 0);
    check("to_header_kept", block_header[HW-1 -: 8], 8'h00);
    send_random(HB);
    cycle(1'b0, 8'h00, 1'b0);
    check("to_next_hv_count", hv_seen, 1);

    // First byte of frame 2 lands in the DONE cycle of frame 1
    hv_seen = 0;
    send_random(2 * HB);
    cycle(1'b0, 8'h00, 1'b0);
    check("done_overlap_hv_count", hv_seen, 2);

    // clear in the same cycle as byte 31
    hv_seen = 0;
    to_seen = 0;
    cnt_before = byte_count;
    send_random(30);
    cycle(1'b1, 8'hA5, 1'b1);
    check("clr_busy", busy, 0);
    check("clr_byte_count", byte_count, cnt_before + 32'd30);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    check("clr_no_pulses", hv_seen + to_seen, 0);

    // Asynchronous reset mid-frame
    send_random(50);
    #2 reset = 1'b1;
    #1;
    check("arst_block_header", block_header, 0);
    check("arst_header_valid", header_valid, 0);
    check("arst_timeout_err", timeout_err, 0);
    check("arst_busy", busy, 0);
    check("arst_byte_count", byte_count, 0);
    model_reset();
    @(negedge clock);
    reset   = 1'b0;
    hv_seen = 0;
    send_random(HB);
    cycle(1'b0, 8'h00, 1'b0);
    check("arst_fresh_hv_count", hv_seen, 1);

    // byte_count wrap
    force dut.byte_cnt = 32'hFFFF_FFFE;
    #1 release dut.byte_cnt;
    m_cnt = 32'hFFFF_FFFE;
    send_random(3);
    check("wrap_byte_count", byte_count, 32'h0000_0001);
    cycle(1'b0, 8'h00, 1'b1);

    // Random traffic with occasional aborts and long gaps
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        repeat (TO - 2 + $urandom_range(0, 4)) cycle(1'b0, 8'h00, 1'b0);
      end else begin
        cycle($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 149) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
